// File: rtl/activation_sequencer.sv
// Activation sequencer: streams a chunk range out of the accumulator buffer,
// through the activation layer, and into the result buffer with a 2-cycle pipeline.
module activation_sequencer #(
    parameter int unsigned N         = 16,
    parameter int unsigned AddrWidth = 10
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic [2:0]           activation_function_i,
    input  logic [AddrWidth-1:0] chunk_count_i,
    input  logic [AddrWidth-1:0] rd_base_i,
    input  logic [AddrWidth-1:0] wr_base_i,
    input  logic                 abort_i,
    output logic                 rd_en_o,
    output logic [AddrWidth-1:0] rd_addr_o,
    output logic                 act_en_o,
    output logic [2:0]           act_fn_o,
    output logic                 wr_en_o,
    output logic [AddrWidth-1:0] wr_addr_o,
    output logic                 busy_o,
    output logic                 done_o
);

    localparam int unsigned FnWidth = 3;

    // Element width only sizes the datapath around this block.
    if (N == 0) begin : g_bad_n
        $error("activation_sequencer: N must be nonzero");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_nxt;
    logic                   w_accept;
    logic                   w_abort;
    logic                   w_last_rd;

    logic [FnWidth-1:0]     r_fn;
    logic [AddrWidth-1:0]   r_cnt;
    logic [AddrWidth-1:0]   r_wr_base;
    logic [AddrWidth-1:0]   r_idx;

    logic                   r_rd_en;
    logic [AddrWidth-1:0]   r_rd_addr;
    logic                   r_v1;
    logic [AddrWidth-1:0]   r_a1;
    logic                   r_wr_en;
    logic [AddrWidth-1:0]   r_wr_addr;
    logic                   r_act_en;
    logic [FnWidth-1:0]     r_act_fn;
    logic                   r_busy;
    logic                   r_done;

    // Next-state logic; abort overrides everything outside IDLE.
    always_comb begin
        w_nxt     = r_state;
        w_accept  = 1'b0;
        w_abort   = abort_i && (r_state != IDLE);
        w_last_rd = (r_idx == r_cnt - AddrWidth'(1));
        unique case (r_state)
            IDLE: begin
                if (start_i) begin
                    w_accept = 1'b1;
                    w_nxt    = (chunk_count_i != '0) ? RUN : DONE;
                end
            end
            RUN:   if (w_last_rd) w_nxt = DRAIN;
            DRAIN: if (!r_v1) w_nxt = DONE;
            DONE:  w_nxt = IDLE;
            default: w_nxt = IDLE;
        endcase
        if (w_abort) w_nxt = IDLE;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) r_state <= IDLE;
        else         r_state <= w_nxt;
    end

    // Job parameters, read index and registered outputs.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_fn      <= '0;
            r_cnt     <= '0;
            r_wr_base <= '0;
            r_idx     <= '0;
            r_rd_en   <= 1'b0;
            r_rd_addr <= '0;
            r_v1      <= 1'b0;
            r_a1      <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_act_en  <= 1'b0;
            r_act_fn  <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_fn      <= activation_function_i;
                r_cnt     <= chunk_count_i;
                r_wr_base <= wr_base_i;
                r_idx     <= '0;
                r_rd_addr <= rd_base_i;
            end else if (r_state == RUN && w_nxt == RUN) begin
                r_idx     <= r_idx + AddrWidth'(1);
                r_rd_addr <= r_rd_addr + AddrWidth'(1);
            end
            r_rd_en   <= (w_nxt == RUN);
            r_v1      <= r_rd_en && !w_abort;
            r_a1      <= r_wr_base + r_idx;
            r_wr_en   <= r_v1 && !w_abort;
            r_wr_addr <= r_a1;
            // Covers read data in flight plus activation output awaiting write.
            r_act_en  <= (r_rd_en || r_v1) && !w_abort;
            r_busy    <= (w_nxt != IDLE);
            r_act_fn  <= (w_nxt == IDLE) ? FnWidth'(0)
                       : (w_accept ? activation_function_i : r_fn);
            r_done    <= (w_nxt == DONE);
        end
    end

    assign rd_en_o   = r_rd_en;
    assign rd_addr_o = r_rd_addr;
    assign act_en_o  = r_act_en;
    assign act_fn_o  = r_act_fn;
    assign wr_en_o   = r_wr_en;
    assign wr_addr_o = r_wr_addr;
    assign busy_o    = r_busy;
    assign done_o    = r_done;

endmodule
